// File: rtl/id_ex_pkg.sv
// Shared types and constants for the ID/EX stage buffer.
// Control field positions, operand indices and parameter defaults.
package id_ex_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NUM_OPS_DEF = 4;
    localparam int CTRL_W_DEF  = 8;
    localparam int RD_W_DEF    = 5;
    localparam int CNT_W_DEF   = 16;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_ALU_OP_LO  = 6;
    localparam int CTRL_ALU_OP_HI  = 7;

    localparam int OP_PC  = 0;
    localparam int OP_RS1 = 1;
    localparam int OP_RS2 = 2;
    localparam int OP_IMM = 3;

    // bit0 = main register valid, bit1 = skid register valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } buf_state_e;

endpackage

// File: rtl/id_ex_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/id_ex_stage_buf.sv
// ID/EX pipeline stage with valid/ready handshake, flush and stall counter.
// Define ID_EX_SKID_EN for the two-entry skid buffer with registered in_ready.
module id_ex_stage_buf
    import id_ex_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int RD_W    = RD_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [RD_W-1:0]         in_rd,
    input  logic [NUM_OPS*XLEN-1:0] in_ops,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [RD_W-1:0]         out_rd,
    output logic [NUM_OPS*XLEN-1:0] out_ops,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int OPS_W = NUM_OPS * XLEN;

    buf_state_e state_q;
    buf_state_e state_d;

    logic [CTRL_W-1:0] m_ctrl;
    logic [RD_W-1:0]   m_rd;
    logic [OPS_W-1:0]  m_ops;

    logic accept;
    logic retire;
    logic load_m_in;
    logic load_m_s;
    logic load_s;
    logic stall_inc;

    assign out_valid = state_q[0];
    assign accept    = in_valid && in_ready && !flush;
    assign retire    = out_valid && out_ready;
    assign stall_inc = out_valid && !out_ready;

`ifdef ID_EX_SKID_EN
    logic [CTRL_W-1:0] s_ctrl;
    logic [RD_W-1:0]   s_rd;
    logic [OPS_W-1:0]  s_ops;

    // state bit1 is the skid valid flop, so in_ready never sees out_ready
    assign in_ready = !state_q[1];
`else
    assign in_ready = !state_q[0] || out_ready;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        load_m_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && retire) begin
                        load_m_in = 1'b1;
                    end else if (retire) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
`ifdef ID_EX_SKID_EN
                        state_d = ST_TWO;
                        load_s  = 1'b1;
`else
                        load_m_in = 1'b1;
`endif
                    end
                end
                ST_TWO: begin
`ifdef ID_EX_SKID_EN
                    if (retire) begin
                        state_d  = ST_ONE;
                        load_m_s = 1'b1;
                    end
`else
                    state_d = ST_EMPTY;
`endif
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl <= '0;
            m_rd   <= '0;
            m_ops  <= '0;
        end else if (load_m_in) begin
            m_ctrl <= in_ctrl;
            m_rd   <= in_rd;
            m_ops  <= in_ops;
`ifdef ID_EX_SKID_EN
        end else if (load_m_s) begin
            m_ctrl <= s_ctrl;
            m_rd   <= s_rd;
            m_ops  <= s_ops;
`endif
        end
    end

`ifdef ID_EX_SKID_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ctrl <= '0;
            s_rd   <= '0;
            s_ops  <= '0;
        end else if (load_s) begin
            s_ctrl <= in_ctrl;
            s_rd   <= in_rd;
            s_ops  <= in_ops;
        end
    end
`else
    logic unused_skid;
    assign unused_skid = load_m_s ^ load_s;
`endif

    assign out_ctrl = m_ctrl & {CTRL_W{out_valid}};
    assign out_rd   = m_rd & {RD_W{out_valid}};
    assign out_ops  = m_ops;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (stall_inc),
        .clr  (cnt_clr),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Directed self-checking bench for id_ex_stage_buf (CNT_W=4).
// Expectations hold for both the skid and single-register builds.
module tb_id_ex_stage_buf;

    localparam int XLEN    = 32;
    localparam int NUM_OPS = 4;
    localparam int CTRL_W  = 8;
    localparam int RD_W    = 5;
    localparam int CNT_W   = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [CTRL_W-1:0]       in_ctrl;
    logic [RD_W-1:0]         in_rd;
    logic [NUM_OPS*XLEN-1:0] in_ops;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [RD_W-1:0]         out_rd;
    logic [NUM_OPS*XLEN-1:0] out_ops;
    logic                    cnt_clr;
    logic [CNT_W-1:0]        stall_cnt;

    int checks = 0;
    int errors = 0;
    int nid;
    logic acc;

    id_ex_stage_buf #(
        .XLEN   (XLEN),
        .NUM_OPS(NUM_OPS),
        .CTRL_W (CTRL_W),
        .RD_W   (RD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_rd    (in_rd),
        .in_ops   (in_ops),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_rd   (out_rd),
        .out_ops  (out_ops),
        .cnt_clr  (cnt_clr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_OPS*XLEN-1:0] mk_ops(
        input logic [31:0] pc, input logic [31:0] r1,
        input logic [31:0] r2, input logic [31:0] imm);
        return {imm, r2, r1, pc};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // advances the presented rd only when the previous offer was taken
    task automatic cyc_track();
        @(negedge clk);
        acc = in_valid && in_ready && !flush;
        @(posedge clk);
        #1;
        if (acc) begin
            nid++;
            in_rd = RD_W'(nid);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_rd     = '0;
        in_ops    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_rd", out_rd, 0);
        check("rst_ops", |out_ops, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_ready", in_ready, 1);

        // single bundle
        #2 reset = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h2D;
        in_rd     = 5'd7;
        in_ops    = mk_ops(32'h104, 32'h11, 32'h22, 32'hFFFF_FFF0);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("one_valid", out_valid, 1);
        check("one_ctrl", out_ctrl, 8'h2D);
        check("one_rd", out_rd, 5'd7);
        check("one_pc", out_ops[31:0], 32'h104);
        check("one_imm", out_ops[127:96], 32'hFFFF_FFF0);
        cyc();
        check("bub_valid", out_valid, 0);
        check("bub_ctrl", out_ctrl, 0);
        check("bub_rd", out_rd, 0);
        check("bub_pc_hold", out_ops[31:0], 32'h104);

        // back-to-back stream
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 8'h10 + 8'(i);
            in_rd    = 5'(i + 1);
            in_ops   = mk_ops(32'h200 + 32'(4 * i), 32'(i), 32'h0, 32'h0);
            cyc();
            check("str_valid", out_valid, 1);
            check("str_rd", out_rd, 64'(i + 1));
            check("str_ctrl", out_ctrl, 64'(8'h10 + 8'(i)));
            check("str_pc", out_ops[31:0], 64'(32'h200 + 32'(4 * i)));
        end
        in_valid = 1'b0;
        cyc();
        check("str_end", out_valid, 0);
        check("str_cnt", stall_cnt, 0);

        // backpressure for three cycles
        nid       = 20;
        in_rd     = 5'd20;
        in_ctrl   = 8'h01;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cyc_track();
        check("bp_rd0", out_rd, 20);
        cyc_track();
        check("bp_ready", in_ready, 0);
        cyc_track();
        cyc_track();
        check("bp_cnt", stall_cnt, 3);
        check("bp_hold", out_rd, 20);
        out_ready = 1'b1;
        cyc_track();
        check("bp_rd1", out_rd, 21);
        cyc_track();
        check("bp_rd2", out_rd, 22);
        in_valid = 1'b0;
        cyc();
        check("bp_drain", out_valid, 0);

        // flush with a full buffer and a new offer
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        check("clr_cnt", stall_cnt, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rd     = 5'd30;
        cyc();
        in_rd = 5'd31;
        cyc();
        check("fl_cnt1", stall_cnt, 1);
        flush = 1'b1;
        in_rd = 5'd32;
        cyc();
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ctrl", out_ctrl, 0);
        check("fl_rd", out_rd, 0);
        check("fl_ready", in_ready, 1);
        check("fl_cnt_kept", stall_cnt, 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        check("fl_gone1", out_valid, 0);
        cyc();
        check("fl_gone2", out_valid, 0);

        // counter saturation and clear priority
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rd     = 5'd9;
        cnt_clr   = 1'b1;
        cyc();
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        check("sat_start", stall_cnt, 0);
        repeat (20) cyc();
        check("sat_max", stall_cnt, 15);
        cnt_clr = 1'b1;
        cyc();
        check("sat_clr", stall_cnt, 0);
        cnt_clr = 1'b0;
        cyc();
        check("sat_inc", stall_cnt, 1);
        check("sat_valid", out_valid, 1);

        // asynchronous reset mid-stall
        reset = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ctrl", out_ctrl, 0);
        check("ar_rd", out_rd, 0);
        check("ar_ops", |out_ops, 0);
        check("ar_cnt", stall_cnt, 0);
        check("ar_ready", in_ready, 1);
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_rd     = 5'd12;
        in_ctrl   = 8'h33;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("rs_valid", out_valid, 1);
        check("rs_rd", out_rd, 12);
        check("rs_ctrl", out_ctrl, 8'h33);
        cyc();
        check("rs_end", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
